// File: rtl/mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// mem_seq_pkg
// Shared definitions for the memory-instruction control sequencer:
//   - opcode values of the memory-class instructions (ld, ldi, st)
//   - step encoding of the sequencer (T0..T7 plus IDLE)
//   - ALU select codes driven on alu_op
//   - width of the memory wait counter
// No ports; imported by every file of the sequencer.
// ---------------------------------------------------------------------------
package mem_seq_pkg;

  // Opcodes of the instructions this sequencer knows how to execute
  localparam logic [4:0] OPC_LD  = 5'b00000;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_ST  = 5'b00010;

  // ALU select codes; only add is used by the address calculation
  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;

  // Wide enough for a hold of up to 15 cycles (load value 14)
  localparam int CNT_W = 4;

  // Step encoding doubles as the t_state output, so T-numbers are literal
  typedef enum logic [3:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_IDLE = 4'd15
  } state_e;

endpackage

// File: rtl/mem_instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_instr_sequencer_if
// Bundle between the control sequencer and the CPU datapath.
//   Datapath -> sequencer : run, ir, mem_ready
//   Sequencer -> datapath : bus source enables (PCout, Zlowout, MDRout, BAout,
//                           Cout, Rout), register loads (PCin, MARin, MDRin,
//                           IRin, Yin, Zlowin, Rin), register selects (Gra,
//                           Grb), IncPC, read, write, alu_op
//   Sequencer status      : t_state, busy, instr_done, illegal_op
// Modports:
//   master - the sequencer (drives the control lines)
//   slave  - the datapath / environment (drives run, ir, mem_ready)
// ---------------------------------------------------------------------------
interface mem_instr_sequencer_if #(
  parameter int IR_W      = 32,
  parameter int ALU_SEL_W = 5
);

  logic                 run;
  logic [IR_W-1:0]      ir;
  logic                 mem_ready;

  logic                 PCout, Zlowout, MDRout, BAout, Cout, Rout;
  logic                 PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin;
  logic                 Gra, Grb;
  logic                 IncPC, read, write;
  logic [ALU_SEL_W-1:0] alu_op;

  logic [3:0]           t_state;
  logic                 busy;
  logic                 instr_done;
  logic                 illegal_op;

  modport master (
    input  run, ir, mem_ready,
    output PCout, Zlowout, MDRout, BAout, Cout, Rout,
    output PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin,
    output Gra, Grb, IncPC, read, write, alu_op,
    output t_state, busy, instr_done, illegal_op
  );

  modport slave (
    output run, ir, mem_ready,
    input  PCout, Zlowout, MDRout, BAout, Cout, Rout,
    input  PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin,
    input  Gra, Grb, IncPC, read, write, alu_op,
    input  t_state, busy, instr_done, illegal_op
  );

endinterface

// File: rtl/mem_wait_counter.sv
// ---------------------------------------------------------------------------
// mem_wait_counter
// Loadable down-counter that measures the minimum hold time of a memory step.
// It stops at zero, so once the minimum time has passed it keeps reporting
// zero for as long as the sequencer waits on mem_ready.
// Ports:
//   clock    - rising-edge clock
//   clear    - asynchronous active-high reset, counter returns to 0
//   load     - load load_val on the next edge (takes priority over counting)
//   load_val - value to load (hold cycles minus one)
//   zero     - counter currently at zero
// ---------------------------------------------------------------------------
module mem_wait_counter
  import mem_seq_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: a load wins, otherwise count down and saturate at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_instr_sequencer.sv
// ---------------------------------------------------------------------------
// mem_instr_sequencer
// Hardwired control unit for the memory-class instructions ld, ldi and st.
// Steps T0-T2 fetch the instruction, T3-T4 form the effective address with
// the ALU, T5-T7 execute. Memory steps (T1, ld T6, st T7) are held for at
// least MEM_LAT cycles and until the memory reports mem_ready.
// Ports:
//   clock - rising-edge clock
//   clear - asynchronous active-high reset (back to IDLE, outputs low)
//   bus   - master side of mem_instr_sequencer_if (run/ir/mem_ready in,
//           datapath control lines and status out)
// Control lines are decoded from the registered step; instr_done on a st
// and illegal_op additionally look at mem_ready / ir in the current cycle.
// ---------------------------------------------------------------------------
module mem_instr_sequencer #(
  parameter int                   IR_W      = 32,
  parameter int                   OPC_W     = 5,
  parameter int                   ALU_SEL_W = 5,
  parameter logic [ALU_SEL_W-1:0] ALU_ADD   = ALU_SEL_W'(mem_seq_pkg::ALU_ADD),
  parameter int                   MEM_LAT   = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  mem_instr_sequencer_if.master bus
);

  import mem_seq_pkg::*;

  localparam logic [OPC_W-1:0] OP_LD    = OPC_W'(OPC_LD);
  localparam logic [OPC_W-1:0] OP_LDI   = OPC_W'(OPC_LDI);
  localparam logic [OPC_W-1:0] OP_ST    = OPC_W'(OPC_ST);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  state_e           endState;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  logic [OPC_W-1:0] irOpcode;
  logic             cntLoad;
  logic             cntZero;
  logic             memExit;

  assign irOpcode = bus.ir[IR_W-1 -: OPC_W];

  // A memory step may be left once its minimum hold has expired and the
  // memory has answered; mem_ready is ignored in every other step
  assign memExit = cntZero && bus.mem_ready;

  // Where to go after the last step of an instruction: straight into the
  // next fetch while run is held, otherwise park in IDLE
  assign endState = bus.run ? ST_T0 : ST_IDLE;

  // Hold-time counter for the memory steps; loaded on the edge that enters
  // a memory step so the first cycle in that step already sees MEM_LAT-1
  mem_wait_counter u_wait (
    .clock    (clock),
    .clear    (clear),
    .load     (cntLoad),
    .load_val (LAT_LOAD),
    .zero     (cntZero)
  );

  // Step register, plus the opcode captured in T3 so that T5-T7 keep
  // executing the same instruction even if ir is reloaded meanwhile
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-step and control decode. Everything defaults to inactive so each
  // step only lists the lines it raises; cntLoad is set on every transition
  // into a memory step
  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    cntLoad        = 1'b0;
    bus.PCout      = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.MDRout     = 1'b0;
    bus.BAout      = 1'b0;
    bus.Cout       = 1'b0;
    bus.Rout       = 1'b0;
    bus.PCin       = 1'b0;
    bus.MARin      = 1'b0;
    bus.MDRin      = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.Zlowin     = 1'b0;
    bus.Rin        = 1'b0;
    bus.Gra        = 1'b0;
    bus.Grb        = 1'b0;
    bus.IncPC      = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.alu_op     = '0;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_T0;
        end
      end

      ST_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
        state_d    = ST_T1;
        cntLoad    = 1'b1;
      end

      ST_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (memExit) begin
          state_d = ST_T2;
        end
      end

      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = ST_T3;
      end

      // IR is valid from here on; anything that is not a memory-class
      // instruction is flagged and dropped without touching the ALU
      ST_T3: begin
        bus.Grb   = 1'b1;
        bus.BAout = 1'b1;
        bus.Yin   = 1'b1;
        opcode_d  = irOpcode;
        if ((irOpcode == OP_LD) || (irOpcode == OP_LDI) || (irOpcode == OP_ST)) begin
          state_d = ST_T4;
        end else begin
          bus.illegal_op = 1'b1;
          state_d        = ST_IDLE;
        end
      end

      ST_T4: begin
        bus.Cout   = 1'b1;
        bus.alu_op = ALU_ADD;
        bus.Zlowin = 1'b1;
        state_d    = ST_T5;
      end

      // ldi is finished once the effective address lands in Ra; ld and st
      // still need to send it to the MAR
      ST_T5: begin
        bus.Zlowout = 1'b1;
        if (opcode_q == OP_LDI) begin
          bus.Gra        = 1'b1;
          bus.Rin        = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = endState;
        end else begin
          bus.MARin = 1'b1;
          state_d   = ST_T6;
          cntLoad   = 1'b1;
        end
      end

      // ld reads memory into the MDR; st loads the MDR from Ra over the bus
      // (read stays low, so the MDR takes its input from the bus)
      ST_T6: begin
        bus.MDRin = 1'b1;
        if (opcode_q == OP_LD) begin
          bus.read = 1'b1;
          if (memExit) begin
            state_d = ST_T7;
          end
        end else begin
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
          state_d  = ST_T7;
          cntLoad  = 1'b1;
        end
      end

      // ld copies the MDR into Ra; st holds write until memory accepts it,
      // and reports completion only in the cycle it leaves
      ST_T7: begin
        if (opcode_q == OP_LD) begin
          bus.MDRout     = 1'b1;
          bus.Gra        = 1'b1;
          bus.Rin        = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = endState;
        end else begin
          bus.write = 1'b1;
          if (memExit) begin
            bus.instr_done = 1'b1;
            state_d        = endState;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.t_state = state_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_instr_sequencer
// Drives two sequencers (MEM_LAT=1 and MEM_LAT=3) through ld, ldi, st,
// a stalled ld, an illegal opcode and an asynchronous clear. A step-level
// model predicts every output each cycle; per-instruction totals are pinned
// with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_mem_instr_sequencer;

  localparam int HALF = 5;

  // Positions inside the packed output snapshot
  localparam int B_PCOUT = 17, B_ZLOWOUT = 16, B_MDROUT = 15, B_BAOUT = 14;
  localparam int B_COUT = 13, B_ROUT = 12, B_PCIN = 11, B_MARIN = 10;
  localparam int B_MDRIN = 9, B_IRIN = 8, B_YIN = 7, B_ZLOWIN = 6, B_RIN = 5;
  localparam int B_GRA = 4, B_GRB = 3, B_INCPC = 2, B_READ = 1, B_WRITE = 0;

  // Indices of the per-DUT activity counters
  localparam int K_BUSY = 0, K_READ = 1, K_WRITE = 2, K_DONE = 3, K_ILL = 4;
  localparam int K_T1 = 5, K_T4 = 6, K_T6 = 7, K_T7 = 8, K_LD7 = 9, K_ST6 = 10;
  localparam int NK = 11;

  localparam logic [31:0] IR_LD  = 32'h0080_0075;
  localparam logic [31:0] IR_LDI = 32'h0880_0075;
  localparam logic [31:0] IR_ST  = 32'h1080_0075;
  localparam logic [31:0] IR_BAD = 32'hF800_0000;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        checkEn = 1'b0;
  logic        runV[2];
  logic [31:0] irV[2];
  logic        readyV[2];
  logic [29:0] obs[2];

  int checkCnt = 0;
  int passCnt  = 0;
  int cnt[2][NK];
  int base[NK];

  int          mStep[2];
  int          mHeld[2];
  logic [4:0]  mOpc[2];

  always #HALF clock = ~clock;

  mem_instr_sequencer_if #(.IR_W(32), .ALU_SEL_W(5)) bus1 ();
  mem_instr_sequencer_if #(.IR_W(32), .ALU_SEL_W(5)) bus3 ();

  assign bus1.run       = runV[0];
  assign bus1.ir        = irV[0];
  assign bus1.mem_ready = readyV[0];
  assign bus3.run       = runV[1];
  assign bus3.ir        = irV[1];
  assign bus3.mem_ready = readyV[1];

  mem_instr_sequencer #(.IR_W(32), .OPC_W(5), .ALU_SEL_W(5), .ALU_ADD(5'b00011), .MEM_LAT(1))
    dut1 (.clock(clock), .clear(clear), .bus(bus1));
  mem_instr_sequencer #(.IR_W(32), .OPC_W(5), .ALU_SEL_W(5), .ALU_ADD(5'b00011), .MEM_LAT(3))
    dut3 (.clock(clock), .clear(clear), .bus(bus3));

  assign obs[0] = {bus1.t_state, bus1.busy, bus1.instr_done, bus1.illegal_op, bus1.alu_op,
                   bus1.PCout, bus1.Zlowout, bus1.MDRout, bus1.BAout, bus1.Cout, bus1.Rout,
                   bus1.PCin, bus1.MARin, bus1.MDRin, bus1.IRin, bus1.Yin, bus1.Zlowin,
                   bus1.Rin, bus1.Gra, bus1.Grb, bus1.IncPC, bus1.read, bus1.write};
  assign obs[1] = {bus3.t_state, bus3.busy, bus3.instr_done, bus3.illegal_op, bus3.alu_op,
                   bus3.PCout, bus3.Zlowout, bus3.MDRout, bus3.BAout, bus3.Cout, bus3.Rout,
                   bus3.PCin, bus3.MARin, bus3.MDRin, bus3.IRin, bus3.Yin, bus3.Zlowin,
                   bus3.Rin, bus3.Gra, bus3.Grb, bus3.IncPC, bus3.read, bus3.write};

  function automatic int latOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit legalOpc(input logic [4:0] o);
    return (o == 5'b00000) || (o == 5'b00001) || (o == 5'b00010);
  endfunction

  function automatic bit isMemStep(input int step, input logic [4:0] opc);
    return (step == 1) || (step == 6 && opc == 5'b00000) || (step == 7 && opc == 5'b00010);
  endfunction

  // Outputs each step must show, written straight from the step table
  function automatic logic [29:0] expectVec(input int step, input logic [4:0] opc,
                                            input logic [4:0] irOp, input bit exiting);
    logic [17:0] c;
    logic [4:0]  alu;
    bit          done;
    bit          ill;
    c = '0; alu = '0; done = 1'b0; ill = 1'b0;
    case (step)
      0: begin c[B_PCOUT] = 1; c[B_MARIN] = 1; c[B_INCPC] = 1; c[B_ZLOWIN] = 1; end
      1: begin c[B_ZLOWOUT] = 1; c[B_PCIN] = 1; c[B_READ] = 1; c[B_MDRIN] = 1; end
      2: begin c[B_MDROUT] = 1; c[B_IRIN] = 1; end
      3: begin c[B_GRB] = 1; c[B_BAOUT] = 1; c[B_YIN] = 1; ill = !legalOpc(irOp); end
      4: begin c[B_COUT] = 1; c[B_ZLOWIN] = 1; alu = 5'b00011; end
      5: begin
        c[B_ZLOWOUT] = 1;
        if (opc == 5'b00001) begin c[B_GRA] = 1; c[B_RIN] = 1; done = 1; end
        else c[B_MARIN] = 1;
      end
      6: begin
        c[B_MDRIN] = 1;
        if (opc == 5'b00000) c[B_READ] = 1;
        else begin c[B_GRA] = 1; c[B_ROUT] = 1; end
      end
      7: begin
        if (opc == 5'b00000) begin c[B_MDROUT] = 1; c[B_GRA] = 1; c[B_RIN] = 1; done = 1; end
        else begin c[B_WRITE] = 1; done = exiting; end
      end
      default: ;
    endcase
    return {4'(step), (step != 15), done, ill, alu, c};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCnt++;
    if (actual === expected) passCnt++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
  endtask

  // Step model: which T-step each DUT is in and how long it has been there
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 2; i++) begin
        mStep[i] <= 15;
        mHeld[i] <= 0;
        mOpc[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mStep[i] == 15) begin
          if (runV[i]) mStep[i] <= 0;
        end else if (isMemStep(mStep[i], mOpc[i]) && !((mHeld[i] + 1 >= latOf(i)) && readyV[i])) begin
          mHeld[i] <= mHeld[i] + 1;
        end else begin
          mHeld[i] <= 0;
          case (mStep[i])
            3: begin
              mOpc[i]  <= irV[i][31:27];
              mStep[i] <= legalOpc(irV[i][31:27]) ? 4 : 15;
            end
            5: mStep[i] <= (mOpc[i] == 5'b00001) ? (runV[i] ? 0 : 15) : 6;
            7: mStep[i] <= runV[i] ? 0 : 15;
            default: mStep[i] <= mStep[i] + 1;
          endcase
        end
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model
  always @(negedge clock) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput((i == 0) ? "cycle dut1" : "cycle dut3", 32'(obs[i]),
                    32'(expectVec(mStep[i], mOpc[i], irV[i][31:27],
                                  isMemStep(mStep[i], mOpc[i]) && (mHeld[i] + 1 >= latOf(i)) && readyV[i])));
      end
    end
  end

  // Activity counters, read as deltas by the directed tests
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (obs[i][25])      cnt[i][K_BUSY]  <= cnt[i][K_BUSY] + 1;
      if (obs[i][B_READ])  cnt[i][K_READ]  <= cnt[i][K_READ] + 1;
      if (obs[i][B_WRITE]) cnt[i][K_WRITE] <= cnt[i][K_WRITE] + 1;
      if (obs[i][24])      cnt[i][K_DONE]  <= cnt[i][K_DONE] + 1;
      if (obs[i][23])      cnt[i][K_ILL]   <= cnt[i][K_ILL] + 1;
      if (obs[i][29:26] == 4'd1) cnt[i][K_T1] <= cnt[i][K_T1] + 1;
      if (obs[i][29:26] == 4'd4) cnt[i][K_T4] <= cnt[i][K_T4] + 1;
      if (obs[i][29:26] == 4'd6) cnt[i][K_T6] <= cnt[i][K_T6] + 1;
      if (obs[i][29:26] == 4'd7) cnt[i][K_T7] <= cnt[i][K_T7] + 1;
      if (obs[i][29:26] == 4'd7 && obs[i][B_MDROUT] && obs[i][B_GRA] && obs[i][B_RIN])
        cnt[i][K_LD7] <= cnt[i][K_LD7] + 1;
      if (obs[i][29:26] == 4'd6 && obs[i][B_ROUT] && obs[i][B_MDRIN] && !obs[i][B_READ])
        cnt[i][K_ST6] <= cnt[i][K_ST6] + 1;
    end
  end

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic snapshot(input int idx);
    for (int k = 0; k < NK; k++) base[k] = cnt[idx][k];
  endtask

  task automatic checkDelta(input string name, input int idx, input int k, input int want);
    checkOutput(name, 32'(cnt[idx][k] - base[k]), 32'(want));
  endtask

  // Pulse run for one instruction and follow it back to IDLE; optionally
  // hold mem_ready low for the first lowInT6 cycles of T6
  task automatic applyStimulus(input string name, input int idx, input logic [31:0] irVal,
                               input int lowInT6);
    int n;
    int lowCnt;
    n = 0;
    lowCnt = 0;
    snapshot(idx);
    irV[idx]  = irVal;
    runV[idx] = 1'b1;
    stepCycle();
    runV[idx] = 1'b0;
    while (mStep[idx] != 15 && n < 200) begin
      stepCycle();
      n++;
      if (mStep[idx] == 6 && lowCnt < lowInT6) begin
        readyV[idx] = 1'b0;
        lowCnt++;
      end else begin
        readyV[idx] = 1'b1;
      end
    end
    checkOutput({name, " back to idle"}, 32'(obs[idx][29:26]), 32'd15);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      runV[i] = 1'b0; irV[i] = '0; readyV[i] = 1'b1;
      for (int k = 0; k < NK; k++) cnt[i][k] = 0;
    end
    clear = 1'b1;
    repeat (3) stepCycle();
    checkOutput("reset dut1", 32'(obs[0]), {2'b00, 4'hF, 26'b0});
    checkOutput("reset dut3", 32'(obs[1]), {2'b00, 4'hF, 26'b0});
    clear   = 1'b0;
    checkEn = 1'b1;
    stepCycle();

    $display("[TB] ld, MEM_LAT=1");
    applyStimulus("ld", 0, IR_LD, 0);
    checkDelta("ld cycles", 0, K_BUSY, 8);
    checkDelta("ld reads", 0, K_READ, 2);
    checkDelta("ld done", 0, K_DONE, 1);
    checkDelta("ld T7 controls", 0, K_LD7, 1);
    checkDelta("ld writes", 0, K_WRITE, 0);

    $display("[TB] ldi");
    applyStimulus("ldi", 0, IR_LDI, 0);
    checkDelta("ldi cycles", 0, K_BUSY, 6);
    checkDelta("ldi reads", 0, K_READ, 1);
    checkDelta("ldi done", 0, K_DONE, 1);
    checkDelta("ldi T6", 0, K_T6, 0);

    $display("[TB] ld with memory stall in T6");
    applyStimulus("ld stall", 0, IR_LD, 5);
    checkDelta("stall cycles", 0, K_BUSY, 13);
    checkDelta("stall T6 cycles", 0, K_T6, 6);
    checkDelta("stall reads", 0, K_READ, 7);
    checkDelta("stall done", 0, K_DONE, 1);

    $display("[TB] illegal opcode with run held");
    snapshot(0);
    irV[0]  = IR_BAD;
    runV[0] = 1'b1;
    repeat (4) stepCycle();
    checkOutput("illegal in T3", 32'(obs[0][29:26]), 32'd3);
    checkOutput("illegal pulse", 32'(obs[0][23]), 32'd1);
    stepCycle();
    checkOutput("illegal to idle", 32'(obs[0][29:26]), 32'd15);
    stepCycle();
    checkOutput("illegal restart", 32'(obs[0][29:26]), 32'd0);
    runV[0] = 1'b0;
    n = 0;
    while (mStep[0] != 15 && n < 50) begin stepCycle(); n++; end
    checkOutput("illegal back to idle", 32'(obs[0][29:26]), 32'd15);
    checkDelta("illegal pulses", 0, K_ILL, 2);
    checkDelta("illegal no T4", 0, K_T4, 0);
    checkDelta("illegal no done", 0, K_DONE, 0);

    $display("[TB] clear during ld T6");
    snapshot(0);
    irV[0]  = IR_LD;
    runV[0] = 1'b1;
    stepCycle();
    runV[0] = 1'b0;
    n = 0;
    while (mStep[0] != 6 && n < 50) begin stepCycle(); n++; end
    #2;
    clear = 1'b1;
    #1;
    checkOutput("clear outputs", 32'(obs[0]), {2'b00, 4'hF, 26'b0});
    stepCycle();
    runV[0] = 1'b1;
    #2;
    clear = 1'b0;
    stepCycle();
    checkOutput("restart after clear", 32'(obs[0][29:26]), 32'd0);
    runV[0] = 1'b0;
    n = 0;
    while (mStep[0] != 15 && n < 50) begin stepCycle(); n++; end
    checkOutput("clear ld back to idle", 32'(obs[0][29:26]), 32'd15);
    checkDelta("clear reads", 0, K_READ, 3);
    checkDelta("clear done", 0, K_DONE, 1);

    $display("[TB] st, MEM_LAT=3");
    applyStimulus("st", 1, IR_ST, 0);
    checkDelta("st cycles", 1, K_BUSY, 12);
    checkDelta("st T1 cycles", 1, K_T1, 3);
    checkDelta("st T7 cycles", 1, K_T7, 3);
    checkDelta("st writes", 1, K_WRITE, 3);
    checkDelta("st reads", 1, K_READ, 3);
    checkDelta("st T6 controls", 1, K_ST6, 1);
    checkDelta("st done", 1, K_DONE, 1);

    stepCycle();
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
